// File: rtl/f1_pkg.sv
// F1 start-light controller: shared types and constants.
// States, light patterns and LFSR feedback mask.
package f1_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LIGHTING,
    HOLD,
    GO,
    RESULT,
    FAULT
  } f1_state_e;

  localparam logic [7:0] LIGHTS_OFF   = 8'h00;
  localparam logic [7:0] LIGHTS_ALL   = 8'hFF;
  localparam logic [7:0] LIGHTS_FAULT = 8'h55;
  localparam logic [7:0] LIGHTS_LAST  = 8'h7F;

  // x^16 + x^14 + x^13 + x^11, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/f1_lfsr.sv
// 16-bit Galois LFSR used as the random hold-delay source.
// Advances on every enabled cycle, reloads SEED on reset.
module f1_lfsr
  import f1_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Shift right, fold the tap mask in when a one drops out
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ LFSR_TAPS;
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst)    lfsr_q <= SEED;
    else if (en) lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/f1_start_ctrl.sv
// F1 start-light sequencer with jump-start detection
// and saturating reaction-time measurement.
module f1_start_ctrl
  import f1_pkg::*;
#(
  parameter int          TICK_DIV    = 24,
  parameter int          DELAY_W     = 5,
  parameter int          REACT_W     = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          FIXED_DELAY = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               trigger,
  output logic [7:0]         lights,
  output logic               cmd_seq,
  output logic               cmd_delay,
  output logic               lights_out,
  output logic               react_valid,
  output logic [REACT_W-1:0] react_time,
  output logic               jump_start
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [REACT_W-1:0] RMAX = '1;
  localparam logic [DELAY_W-1:0] DFIX = DELAY_W'(FIXED_DELAY);
  localparam logic [DELAY_W-1:0] DONE = DELAY_W'(1);

  f1_state_e          state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [DELAY_W-1:0] dly_q, dly_d;
  logic [DELAY_W-1:0] dly_raw, dly_load;
  logic [REACT_W-1:0] rcnt_q, rcnt_d;
  logic [REACT_W-1:0] rtime_q, rtime_d;
  logic [7:0]         lights_q, lights_d;
  logic               seq_q, seq_d;
  logic               hold_q, hold_d;
  logic               lo_q, lo_d;
  logic               rv_q, rv_d;
  logic               js_q, js_d;
  logic               trig_q;
  logic               trig_rise;
  logic               tick;
  logic [15:0]        lfsr;
  logic               unused_lfsr;

  f1_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .q   (lfsr)
  );

  assign unused_lfsr = ^lfsr;
  assign trig_rise = trigger & ~trig_q;
  assign tick = en & (presc_q == PMAX);

  assign dly_raw  = (FIXED_DELAY != 0) ? DFIX
                                       : lfsr[DELAY_W-1:0];
  assign dly_load = (dly_raw == '0) ? DONE : dly_raw;

  // Button history runs even when frozen, so frozen presses are lost
  always_ff @(posedge clk) begin
    if (!rst) trig_q <= 1'b0;
    else      trig_q <= trigger;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst)    state_q <= IDLE;
    else if (en) state_q <= state_d;
  end

  // FSM next state: a press always beats a tick
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (trig_rise) state_d = LIGHTING;
      LIGHTING:
        if (trig_rise) state_d = FAULT;
        else if (tick && lights_q == LIGHTS_LAST)
          state_d = HOLD;
      HOLD:
        if (trig_rise) state_d = FAULT;
        else if (tick && dly_q == DONE)
          state_d = GO;
      GO:
        if (trig_rise || rcnt_q == RMAX)
          state_d = RESULT;
      RESULT:
        if (trig_rise) state_d = IDLE;
      FAULT:
        if (trig_rise) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // FSM outputs and datapath next values
  always_comb begin
    presc_d = (presc_q == PMAX) ? '0 : presc_q + 1'b1;
    if (state_q == IDLE && state_d == LIGHTING)
      presc_d = '0;

    dly_d = dly_q;
    if (state_q == LIGHTING && state_d == HOLD)
      dly_d = dly_load;
    else if (state_q == HOLD && tick)
      dly_d = dly_q - DONE;

    rcnt_d = rcnt_q;
    if (state_q != GO && state_d == GO)
      rcnt_d = '0;
    else if (state_q == GO && rcnt_q != RMAX)
      rcnt_d = rcnt_q + 1'b1;

    rtime_d = rtime_q;
    if (state_q == GO && state_d == RESULT)
      rtime_d = rcnt_q;

    lights_d = LIGHTS_OFF;
    unique case (state_d)
      LIGHTING:
        if (state_q == IDLE) lights_d = 8'h01;
        else if (tick) lights_d = {lights_q[6:0], 1'b1};
        else lights_d = lights_q;
      HOLD:    lights_d = LIGHTS_ALL;
      FAULT:   lights_d = LIGHTS_FAULT;
      default: lights_d = LIGHTS_OFF;
    endcase

    seq_d  = (state_d == LIGHTING);
    hold_d = (state_d == HOLD);
    rv_d   = (state_d == RESULT);
    lo_d   = (state_d == GO) && (state_q != GO);
    js_d   = (state_d == FAULT) && (state_q != FAULT);
  end

  // Registered outputs, prescaler and counters; en low freezes all
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q  <= '0;
      dly_q    <= '0;
      rcnt_q   <= '0;
      rtime_q  <= '0;
      lights_q <= LIGHTS_OFF;
      seq_q    <= 1'b0;
      hold_q   <= 1'b0;
      lo_q     <= 1'b0;
      rv_q     <= 1'b0;
      js_q     <= 1'b0;
    end else if (en) begin
      presc_q  <= presc_d;
      dly_q    <= dly_d;
      rcnt_q   <= rcnt_d;
      rtime_q  <= rtime_d;
      lights_q <= lights_d;
      seq_q    <= seq_d;
      hold_q   <= hold_d;
      lo_q     <= lo_d;
      rv_q     <= rv_d;
      js_q     <= js_d;
    end
  end

  assign lights      = lights_q;
  assign cmd_seq     = seq_q;
  assign cmd_delay   = hold_q;
  assign lights_out  = lo_q;
  assign react_valid = rv_q;
  assign react_time  = rtime_q;
  assign jump_start  = js_q;

endmodule

// File: tb/tb_f1_start_ctrl.sv
// Bench for f1_start_ctrl: fixed-delay instance A and
// LFSR-delay, 4-bit reaction instance B.
module tb_f1_start_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rst_edge_b = 0;

  logic        rst_a, en_a, trig_a;
  logic [7:0]  lights_a;
  logic        cmd_seq_a, cmd_delay_a, lights_out_a;
  logic        react_valid_a, jump_start_a;
  logic [15:0] react_time_a;

  logic        rst_b, en_b, trig_b;
  logic [7:0]  lights_b;
  logic        cmd_seq_b, cmd_delay_b, lights_out_b;
  logic        react_valid_b, jump_start_b;
  logic [3:0]  react_time_b;

  f1_start_ctrl #(
    .TICK_DIV(4), .DELAY_W(5), .REACT_W(16),
    .LFSR_SEED(16'hACE1), .FIXED_DELAY(3)
  ) u_a (
    .clk(clk), .rst(rst_a), .en(en_a), .trigger(trig_a),
    .lights(lights_a), .cmd_seq(cmd_seq_a),
    .cmd_delay(cmd_delay_a), .lights_out(lights_out_a),
    .react_valid(react_valid_a), .react_time(react_time_a),
    .jump_start(jump_start_a)
  );

  f1_start_ctrl #(
    .TICK_DIV(4), .DELAY_W(5), .REACT_W(4),
    .LFSR_SEED(16'hACE1), .FIXED_DELAY(0)
  ) u_b (
    .clk(clk), .rst(rst_b), .en(en_b), .trigger(trig_b),
    .lights(lights_b), .cmd_seq(cmd_seq_b),
    .cmd_delay(cmd_delay_b), .lights_out(lights_out_b),
    .react_valid(react_valid_b), .react_time(react_time_b),
    .jump_start(jump_start_b)
  );

  logic [12:0] vec_a, vec_b;
  assign vec_a = {lights_a, cmd_seq_a, cmd_delay_a,
                  lights_out_a, react_valid_a, jump_start_a};
  assign vec_b = {lights_b, cmd_seq_b, cmd_delay_b,
                  lights_out_b, react_valid_b, jump_start_b};

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Observable outputs c cycles after a start press, hold of d ticks
  function automatic logic [12:0] exp_vec(int c, int d);
    int gc;
    logic [7:0] l;
    gc = 29 + 4 * d;
    if (c < 29)      l = 8'((1 << ((c - 1) / 4 + 1)) - 1);
    else if (c < gc) l = 8'hFF;
    else             l = 8'h00;
    return {l, c < 29, (c >= 29) && (c < gc), c == gc,
            1'b0, 1'b0};
  endfunction

  // Polynomial x^16+x^14+x^13+x^11 stepped n times
  function automatic logic [15:0] lfsr_adv(logic [15:0] s,
                                           int n);
    for (int i = 0; i < n; i++)
      s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    return s;
  endfunction

  task automatic test_reset();
    rst_a = 0; rst_b = 0; en_a = 1; en_b = 1;
    trig_a = 0; trig_b = 0;
    repeat (3) step();
    rst_edge_b = cyc;
    rst_a = 1; rst_b = 1;
    checks++;
    if (vec_a !== 13'h0 || react_time_a !== 16'h0) begin
      errors++;
      $display("FAIL reset_a got %h/%h exp 0/0",
               vec_a, react_time_a);
    end
    checks++;
    if (vec_b !== 13'h0 || react_time_b !== 4'h0) begin
      errors++;
      $display("FAIL reset_b got %h/%h exp 0/0",
               vec_b, react_time_b);
    end
  endtask

  task automatic test_sequence();
    int r;
    for (int it = 0; it < 4; it++) begin
      r = (it == 0) ? 100 : int'($urandom_range(0, 400));
      trig_a = 1;
      for (int c = 1; c <= 41; c++) begin
        step();
        if (c == 1) trig_a = 0;
        checks++;
        if (vec_a !== exp_vec(c, 3)) begin
          errors++;
          $display("FAIL seq c=%0d got %h exp %h",
                   c, vec_a, exp_vec(c, 3));
        end
      end
      for (int k = 0; k < r; k++) begin
        step();
        checks++;
        if (react_valid_a !== 0 || lights_a !== 0) begin
          errors++;
          $display("FAIL go_wait k=%0d got rv=%b l=%h exp 0/00",
                   k, react_valid_a, lights_a);
        end
      end
      trig_a = 1; step(); trig_a = 0;
      checks++;
      if (react_valid_a !== 1 || react_time_a !== 16'(r)) begin
        errors++;
        $display("FAIL react got %b/%0d exp 1/%0d",
                 react_valid_a, react_time_a, r);
      end
      step();
      checks++;
      if (react_valid_a !== 1 || react_time_a !== 16'(r)) begin
        errors++;
        $display("FAIL react_hold got %b/%0d exp 1/%0d",
                 react_valid_a, react_time_a, r);
      end
      trig_a = 1; step(); trig_a = 0;
      checks++;
      if (vec_a !== 13'h0 || react_time_a !== 16'(r)) begin
        errors++;
        $display("FAIL result_exit got %h/%0d exp 0/%0d",
                 vec_a, react_time_a, r);
      end
      step();
    end
  endtask

  task automatic test_jump_start();
    int fl[6];
    fl[0] = 10; fl[1] = 8; fl[2] = 28; fl[3] = 40;
    fl[4] = int'($urandom_range(2, 40));
    fl[5] = int'($urandom_range(2, 40));
    foreach (fl[i]) begin
      trig_a = 1;
      for (int c = 1; c <= fl[i]; c++) begin
        step();
        if (c == 1) trig_a = 0;
        checks++;
        if (vec_a !== exp_vec(c, 3)) begin
          errors++;
          $display("FAIL js_pre c=%0d got %h exp %h",
                   c, vec_a, exp_vec(c, 3));
        end
      end
      trig_a = 1; step(); trig_a = 0;
      checks++;
      if (vec_a !== {8'h55, 5'b00001}) begin
        errors++;
        $display("FAIL fault_entry f=%0d got %h exp %h",
                 fl[i], vec_a, {8'h55, 5'b00001});
      end
      step();
      checks++;
      if (vec_a !== {8'h55, 5'b00000}) begin
        errors++;
        $display("FAIL fault_hold f=%0d got %h exp %h",
                 fl[i], vec_a, {8'h55, 5'b00000});
      end
      trig_a = 1; step(); trig_a = 0;
      checks++;
      if (vec_a !== 13'h0) begin
        errors++;
        $display("FAIL fault_exit f=%0d got %h exp 0",
                 fl[i], vec_a);
      end
      step();
    end
  endtask

  task automatic test_freeze();
    int c0, n, eff;
    for (int it = 0; it < 3; it++) begin
      c0 = (it == 0) ? 9 : int'($urandom_range(2, 24));
      n  = (it == 0) ? 10 : int'($urandom_range(2, 20));
      trig_a = 1;
      for (int c = 1; c <= 41 + n; c++) begin
        step();
        if (c == 1) trig_a = 0;
        eff = (c <= c0) ? c : ((c <= c0 + n) ? c0 : c - n);
        checks++;
        if (vec_a !== exp_vec(eff, 3)) begin
          errors++;
          $display("FAIL freeze c=%0d c0=%0d n=%0d got %h exp %h",
                   c, c0, n, vec_a, exp_vec(eff, 3));
        end
        en_a = !(c >= c0 && c < c0 + n);
        if (c == c0 + 1) trig_a = 1;
        if (c == c0 + n + 3) trig_a = 0;
      end
      en_a = 1;
      trig_a = 1; step(); trig_a = 0;
      checks++;
      if (react_valid_a !== 1) begin
        errors++;
        $display("FAIL freeze_result got %b exp 1",
                 react_valid_a);
      end
      step();
      trig_a = 1; step(); trig_a = 0;
      checks++;
      if (vec_a !== 13'h0) begin
        errors++;
        $display("FAIL freeze_idle got %h exp 0", vec_a);
      end
      step();
    end
  endtask

  task automatic test_random_delay();
    logic [15:0] lf;
    int d, e0, n;
    trig_b = 1; step(); trig_b = 0;
    e0 = cyc;
    lf = lfsr_adv(16'hACE1, e0 + 27 - rst_edge_b);
    d = int'(lf[4:0]);
    if (d == 0) d = 1;
    n = 0;
    while (lights_out_b !== 1 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (lights_out_b !== 1) begin
      errors++;
      $display("FAIL lights_out_wait got none exp pulse d=%0d", d);
    end else if (cyc != e0 + 28 + 4 * d || lights_b !== 0) begin
      errors++;
      $display("FAIL rand_delay got edge %0d exp %0d (d=%0d)",
               cyc - e0, 28 + 4 * d, d);
    end
  endtask

  task automatic test_timeout();
    for (int j = 1; j <= 16; j++) begin
      step();
      checks++;
      if (react_valid_b !== (j == 16) ||
          (j == 16 && react_time_b !== 4'hF)) begin
        errors++;
        $display("FAIL timeout j=%0d got %b/%h exp %b/F",
                 j, react_valid_b, react_time_b, j == 16);
      end
    end
    trig_b = 1; step(); trig_b = 0;
    checks++;
    if (vec_b !== 13'h0 || react_time_b !== 4'hF) begin
      errors++;
      $display("FAIL timeout_exit got %h/%h exp 0/F",
               vec_b, react_time_b);
    end
    step();
  endtask

  task automatic test_reset_hold();
    int n;
    trig_b = 1; step(); trig_b = 0;
    n = 0;
    while (cmd_delay_b !== 1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (cmd_delay_b !== 1) begin
      errors++;
      $display("FAIL reach_hold got %b exp 1", cmd_delay_b);
    end
    step(); step();
    rst_b = 0; step();
    rst_edge_b = cyc;
    rst_b = 1;
    checks++;
    if (vec_b !== 13'h0 || react_time_b !== 4'h0) begin
      errors++;
      $display("FAIL reset_hold got %h/%h exp 0/0",
               vec_b, react_time_b);
    end
    repeat ($urandom_range(0, 10)) step();
    checks++;
    if (vec_b !== 13'h0) begin
      errors++;
      $display("FAIL reset_idle got %h exp 0", vec_b);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_jump_start();
    test_freeze();
    test_random_delay();
    test_timeout();
    test_reset_hold();
    test_random_delay();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
